// File: rtl/sys_cmd_decoder_if.sv
// Byte stream in from the RX synchroniser and register-file / ALU control strobes out.
// The decoder takes the slave side; whoever feeds bytes and consumes strobes takes master.
interface sys_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rf_wr_en;
  logic                  rf_rd_en;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic                  alu_en;
  logic [FUN_WIDTH-1:0]  alu_fun;
  logic                  frame_done;
  logic                  cmd_err;

  modport master (
    output rx_data, rx_valid,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, frame_done, cmd_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun, frame_done, cmd_err
  );
endinterface

// File: rtl/sys_cmd_decoder.sv
// Command-frame parser: each accepted byte yields registered strobes one cycle later; no backpressure.
// SYS_CMD_DECODER_TIMEOUT_EN adds a mid-frame idle timeout that aborts the frame with cmd_err.
module sys_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  sys_cmd_decoder_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sys_cmd_decoder: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_ALU_OPA,
    S_ALU_OPB,
    S_ALU_FUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_cap_q, addr_cap_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  frame_done_q, frame_done_d;
  logic                  cmd_err_q, cmd_err_d;

  logic                  byte_vld;
  logic [DATA_WIDTH-1:0] byte_dat;

  assign byte_vld = bus.rx_valid;
  assign byte_dat = bus.rx_data;

`ifdef SYS_CMD_DECODER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;

  // A byte arriving in the last tolerated cycle still wins over the timeout.
  assign tmo_hit = (state_q != S_IDLE) && !byte_vld && (tmo_cnt_q == CNT_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    if (byte_vld || state_q == S_IDLE || tmo_hit) begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    addr_cap_d   = addr_cap_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_en_d     = 1'b0;
    alu_fun_d    = alu_fun_q;
    frame_done_d = 1'b0;
    cmd_err_d    = 1'b0;

    if (byte_vld) begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_dat == CMD_WR) begin
            state_d = S_WR_ADDR;
          end else if (byte_dat == CMD_RD) begin
            state_d = S_RD_ADDR;
          end else if (byte_dat == CMD_ALU) begin
            state_d = S_ALU_OPA;
          end else if (byte_dat == CMD_ALU_NO) begin
            state_d = S_ALU_FUN;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        S_WR_ADDR: begin
          addr_cap_d = byte_dat[ADDR_WIDTH-1:0];
          state_d    = S_WR_DATA;
        end
        S_WR_DATA: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = addr_cap_q;
          rf_wr_data_d = byte_dat;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
        S_RD_ADDR: begin
          rf_rd_en_d   = 1'b1;
          rf_addr_d    = byte_dat[ADDR_WIDTH-1:0];
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
        // ALU operands land in the two lowest registers before the ALU is started.
        S_ALU_OPA: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(0);
          rf_wr_data_d = byte_dat;
          state_d      = S_ALU_OPB;
        end
        S_ALU_OPB: begin
          rf_wr_en_d   = 1'b1;
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = byte_dat;
          state_d      = S_ALU_FUN;
        end
        S_ALU_FUN: begin
          alu_en_d     = 1'b1;
          alu_fun_d    = byte_dat[FUN_WIDTH-1:0];
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
`ifdef SYS_CMD_DECODER_TIMEOUT_EN
    end else if (tmo_hit) begin
      state_d   = S_IDLE;
      cmd_err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_cap_q   <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      frame_done_q <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_cap_q   <= addr_cap_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      frame_done_q <= frame_done_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign bus.rf_wr_en   = rf_wr_en_q;
  assign bus.rf_rd_en   = rf_rd_en_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_wr_data = rf_wr_data_q;
  assign bus.alu_en     = alu_en_q;
  assign bus.alu_fun    = alu_fun_q;
  assign bus.frame_done = frame_done_q;
  assign bus.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Directed bench for sys_cmd_decoder: vector table plus hand-written timeout sequences.
// Expected outputs are packed as {wr, rd, addr[3:0], wdata[7:0], alu, fun[3:0], done, err}.
module tb_sys_cmd_decoder;

  logic clk;
  logic rst;

  sys_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus ();

  sys_cmd_decoder #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .FUN_WIDTH     (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic [20:0] exp;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  function automatic logic [20:0] pk(input logic wr, input logic rd, input logic [3:0] addr,
                                     input logic [7:0] wd, input logic alu, input logic [3:0] fun,
                                     input logic done, input logic err);
    return {wr, rd, addr, wd, alu, fun, done, err};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input logic [20:0] e);
    vec_t t;
    t.r = r;
    t.v = v;
    t.d = d;
    t.exp = e;
    return t;
  endfunction

  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic [20:0] exp, input string name);
    logic [20:0] act;
    @(negedge clk);
    rst          = r;
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
    act = {bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data,
           bus.alu_en, bus.alu_fun, bus.frame_done, bus.cmd_err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {wr,rd,addr,wd,alu,fun,done,err}=%b_%b_%h_%h_%b_%h_%b_%b want %b_%b_%h_%h_%b_%h_%b_%b",
               name, act[20], act[19], act[18:15], act[14:7], act[6], act[5:2], act[1], act[0],
               exp[20], exp[19], exp[18:15], exp[14:7], exp[6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    vecs[0]  = mk(1, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[1]  = mk(1, 1, 8'hAA, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    // Register write with 3-cycle gaps; idle data must be ignored.
    vecs[2]  = mk(0, 1, 8'hAA, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[3]  = mk(0, 0, 8'h55, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[4]  = mk(0, 0, 8'h55, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[5]  = mk(0, 0, 8'h55, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[6]  = mk(0, 1, 8'h05, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[7]  = mk(0, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[8]  = mk(0, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[9]  = mk(0, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[10] = mk(0, 1, 8'h3C, pk(1, 0, 4'h5, 8'h3C, 0, 4'h0, 1, 0));
    vecs[11] = mk(0, 0, 8'hDD, pk(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0));
    // Read with address truncation, then an ignored non-valid byte in IDLE.
    vecs[12] = mk(0, 1, 8'hBB, pk(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0));
    vecs[13] = mk(0, 1, 8'h17, pk(0, 1, 4'h7, 8'h3C, 0, 4'h0, 1, 0));
    vecs[14] = mk(0, 0, 8'h66, pk(0, 0, 4'h7, 8'h3C, 0, 4'h0, 0, 0));
    // ALU full frame back-to-back, then bad command and operand-less ALU.
    vecs[15] = mk(0, 1, 8'hCC, pk(0, 0, 4'h7, 8'h3C, 0, 4'h0, 0, 0));
    vecs[16] = mk(0, 1, 8'h12, pk(1, 0, 4'h0, 8'h12, 0, 4'h0, 0, 0));
    vecs[17] = mk(0, 1, 8'h34, pk(1, 0, 4'h1, 8'h34, 0, 4'h0, 0, 0));
    vecs[18] = mk(0, 1, 8'h03, pk(0, 0, 4'h1, 8'h34, 1, 4'h3, 1, 0));
    vecs[19] = mk(0, 1, 8'h55, pk(0, 0, 4'h1, 8'h34, 0, 4'h3, 0, 1));
    vecs[20] = mk(0, 1, 8'hDD, pk(0, 0, 4'h1, 8'h34, 0, 4'h3, 0, 0));
    vecs[21] = mk(0, 1, 8'h0A, pk(0, 0, 4'h1, 8'h34, 1, 4'hA, 1, 0));
    // Command-valued bytes inside a frame are payload.
    vecs[22] = mk(0, 1, 8'hAA, pk(0, 0, 4'h1, 8'h34, 0, 4'hA, 0, 0));
    vecs[23] = mk(0, 1, 8'hBB, pk(0, 0, 4'h1, 8'h34, 0, 4'hA, 0, 0));
    vecs[24] = mk(0, 1, 8'hCC, pk(1, 0, 4'hB, 8'hCC, 0, 4'hA, 1, 0));
    // Reset mid-frame discards it; 0x33 is then an unknown command.
    vecs[25] = mk(0, 1, 8'hAA, pk(0, 0, 4'hB, 8'hCC, 0, 4'hA, 0, 0));
    vecs[26] = mk(0, 1, 8'h02, pk(0, 0, 4'hB, 8'hCC, 0, 4'hA, 0, 0));
    vecs[27] = mk(1, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs[28] = mk(0, 1, 8'h33, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 1));
    vecs[29] = mk(0, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].exp, $sformatf("vec[%0d]", i));
    end

    // A byte arriving on the last tolerated idle cycle is accepted in either build.
    step(1, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0), "edge_reset");
    step(0, 1, 8'hCC, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0), "edge_cmd");
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0), $sformatf("edge_idle%0d", i));
    end
    step(0, 1, 8'h12, pk(1, 0, 4'h0, 8'h12, 0, 4'h0, 0, 0), "edge_opa");
    step(0, 1, 8'h34, pk(1, 0, 4'h1, 8'h34, 0, 4'h0, 0, 0), "edge_opb");
    step(0, 1, 8'h05, pk(0, 0, 4'h1, 8'h34, 1, 4'h5, 1, 0), "edge_fun");

    // Eight idle cycles after CC: timeout build aborts, default build keeps waiting.
    step(1, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0), "tmo_reset");
    step(0, 1, 8'hCC, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0), "tmo_cmd");
    for (int i = 0; i < 8; i++) begin
`ifdef SYS_CMD_DECODER_TIMEOUT_EN
      step(0, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, (i == 7)), $sformatf("tmo_idle%0d", i));
`else
      step(0, 0, 8'h00, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0), $sformatf("tmo_idle%0d", i));
`endif
    end
`ifdef SYS_CMD_DECODER_TIMEOUT_EN
    step(0, 1, 8'hBB, pk(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0), "tmo_rd_cmd");
    step(0, 1, 8'h01, pk(0, 1, 4'h1, 8'h00, 0, 4'h0, 1, 0), "tmo_rd_addr");
`else
    step(0, 1, 8'hBB, pk(1, 0, 4'h0, 8'hBB, 0, 4'h0, 0, 0), "wait_opa");
    step(0, 1, 8'h01, pk(1, 0, 4'h1, 8'h01, 0, 4'h0, 0, 0), "wait_opb");
`endif
    step(0, 0, 8'h00, {2'b00, bus.rf_addr, bus.rf_wr_data, 1'b0, bus.alu_fun, 2'b00}, "quiet");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
